// File: rtl/rail_crossing_ctrl_mt.sv
// Multi-track level-crossing controller: per-track occupancy counters feed a timed
// FSM that sequences road lights, gate motor command and track signals.
module rail_crossing_ctrl_mt #(
  parameter int unsigned N_TRACKS     = 2,
  parameter int unsigned OCC_W        = 3,
  parameter int unsigned WARN_CYCLES  = 8,
  parameter int unsigned CLEAR_CYCLES = 4,
  parameter int unsigned GATE_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [N_TRACKS-1:0]     train_in,
  input  logic [N_TRACKS-1:0]     train_out,
  input  logic                    gate_down,
  input  logic                    gate_up,
  output logic [1:0]              road,
  output logic [2*N_TRACKS-1:0]   track,
  output logic                    gate_cmd,
  output logic                    busy,
  output logic                    fault,
  output logic                    seq_err
);

  localparam logic [1:0] SIG_RED = 2'b00;
  localparam logic [1:0] SIG_YEL = 2'b01;
  localparam logic [1:0] SIG_GRN = 2'b10;

  localparam logic [OCC_W-1:0] OCC_MAX = '1;

  localparam int unsigned MAX_WC  = (WARN_CYCLES > CLEAR_CYCLES) ? WARN_CYCLES : CLEAR_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_WC > GATE_TIMEOUT) ? MAX_WC : GATE_TIMEOUT;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] LD_WARN  = TMR_W'(WARN_CYCLES - 1);
  localparam logic [TMR_W-1:0] LD_CLEAR = TMR_W'(CLEAR_CYCLES - 1);
  localparam logic [TMR_W-1:0] LD_GATE  = TMR_W'(GATE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_OPEN,
    ST_WARN,
    ST_LOWER,
    ST_CLOSED,
    ST_CLEAR,
    ST_RAISE,
    ST_FAULT
  } state_e;

  state_e                         state_q, state_d;
  logic [TMR_W-1:0]               tmr_q, tmr_d;
  logic [N_TRACKS-1:0][OCC_W-1:0] occ_q, occ_d;
  logic                           seq_err_q, seq_err_d;
  logic                           busy_q;
  logic                           fault_q, fault_d;
  logic                           gate_cmd_q, gate_cmd_d;
  logic [1:0]                     road_q, road_d;
  logic [2*N_TRACKS-1:0]          track_q, track_d;

  logic any_occ;
  logic arrive;
  logic sensor_bad;
  logic tmr_zero;

  assign arrive     = |train_in;
  assign sensor_bad = gate_down & gate_up;
  assign tmr_zero   = (tmr_q == '0);

  // Occupancy counters: simultaneous in/out cancels; over/underflow is flagged sticky.
  always_comb begin
    occ_d     = occ_q;
    seq_err_d = seq_err_q;
    any_occ   = 1'b0;
    for (int i = 0; i < int'(N_TRACKS); i++) begin
      if (train_in[i] && !train_out[i]) begin
        if (occ_q[i] == OCC_MAX) seq_err_d = 1'b1;
        else                     occ_d[i] = occ_q[i] + OCC_W'(1);
      end else if (train_out[i] && !train_in[i]) begin
        if (occ_q[i] == '0) seq_err_d = 1'b1;
        else                occ_d[i] = occ_q[i] - OCC_W'(1);
      end
      any_occ = any_occ | (|occ_d[i]);
    end
  end

  // Sequencing FSM; outputs are decoded from the next state and registered.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    road_d     = SIG_RED;
    track_d    = {N_TRACKS{SIG_RED}};
    gate_cmd_d = 1'b1;
    fault_d    = 1'b0;

    unique case (state_q)
      ST_OPEN: begin
        if (arrive) begin
          state_d = ST_WARN;
          tmr_d   = LD_WARN;
        end
      end
      ST_WARN: begin
        if (tmr_zero) begin
          state_d = ST_LOWER;
          tmr_d   = LD_GATE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_LOWER: begin
        if (sensor_bad)     state_d = ST_FAULT;
        else if (gate_down) state_d = ST_CLOSED;
        else if (tmr_zero)  state_d = ST_FAULT;
        else                tmr_d   = tmr_q - TMR_W'(1);
      end
      ST_CLOSED: begin
        if (!any_occ) begin
          state_d = ST_CLEAR;
          tmr_d   = LD_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (arrive) begin
          state_d = ST_CLOSED;
        end else if (tmr_zero) begin
          state_d = ST_RAISE;
          tmr_d   = LD_GATE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_RAISE: begin
        if (sensor_bad) begin
          state_d = ST_FAULT;
        end else if (arrive) begin
          state_d = ST_LOWER;
          tmr_d   = LD_GATE;
        end else if (gate_up) begin
          state_d = ST_OPEN;
        end else if (tmr_zero) begin
          state_d = ST_FAULT;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase

    unique case (state_d)
      ST_OPEN: begin
        road_d     = SIG_GRN;
        gate_cmd_d = 1'b0;
      end
      ST_WARN: begin
        road_d     = SIG_YEL;
        gate_cmd_d = 1'b0;
      end
      ST_CLOSED: track_d    = {N_TRACKS{SIG_GRN}};
      ST_RAISE:  gate_cmd_d = 1'b0;
      ST_FAULT: begin
        track_d = {N_TRACKS{SIG_YEL}};
        fault_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_OPEN;
      tmr_q      <= '0;
      occ_q      <= '0;
      seq_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      gate_cmd_q <= 1'b0;
      road_q     <= SIG_GRN;
      track_q    <= {N_TRACKS{SIG_RED}};
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      occ_q      <= occ_d;
      seq_err_q  <= seq_err_d;
      busy_q     <= any_occ;
      fault_q    <= fault_d;
      gate_cmd_q <= gate_cmd_d;
      road_q     <= road_d;
      track_q    <= track_d;
    end
  end

  assign road     = road_q;
  assign track    = track_q;
  assign gate_cmd = gate_cmd_q;
  assign busy     = busy_q;
  assign fault    = fault_q;
  assign seq_err  = seq_err_q;

endmodule

// File: doc/rail_crossing_ctrl_mt.md
Name: rail_crossing_ctrl_mt

Overview:
- Parametrised multi-track level-crossing controller; successor to the single-track rail gate controller.
- Tracks per-track train occupancy from approach/exit sensors and sequences road lights, gate motor and track signals through a timed FSM.
- Adds gate-position handshake, gate timeout fault, re-trigger handling and sequence-error flagging.
- Sits between trackside sensors and the signal/gate drivers.

Parameters:
N_TRACKS, 2, number of tracks crossing the road (1..8)
OCC_W, 3, occupancy counter width per track (max trains per track = 2^OCC_W-1)
WARN_CYCLES, 8, road-yellow duration before gate lowering (>=1)
CLEAR_CYCLES, 4, hold after last exit before raising (>=1)
GATE_TIMEOUT, 16, max cycles to wait for gate limit switch (>=2)

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-high reset
train_in  input  N_TRACKS  approach sensor pulse per track, 1-cycle, sampled on clk
train_out  input  N_TRACKS  exit sensor pulse per track, 1-cycle
gate_down  input  1  limit switch, gate fully down
gate_up  input  1  limit switch, gate fully up
road  output  2  road light: 2'b00 RED, 2'b01 YELLOW, 2'b10 GREEN
track  output  2*N_TRACKS  per-track signal, same encoding; track i at [2i+1:2i]
gate_cmd  output  1  1 = drive gate down, 0 = drive up
busy  output  1  any occupancy counter nonzero
fault  output  1  sticky gate-timeout fault
seq_err  output  1  sticky occupancy underflow/overflow

Behaviour:
- One clock (clk); reset (clr) is asynchronous and active-high.
- All outputs registered.
- Reset values: road=GREEN, track=all RED, gate_cmd=0, busy=0, fault=0, seq_err=0, all counters 0, FSM=OPEN, timers 0.
- Occupancy, per track, updated on every edge:
  - train_in only: +1.
  - train_out only: -1.
  - Both asserted: no change.
  - Increment at max: saturate, set seq_err.
  - Decrement at 0: stays 0, set seq_err.
- any_occ = OR of counters after the update. busy reflects the registered counters, so it lags train_in by one edge.
- arrive = OR of train_in this cycle.
- FSM states and transitions (evaluated on the same edge that samples inputs; outputs reflect the new state after that edge):
  - OPEN: road GREEN, gate_cmd 0, tracks RED. arrive -> WARN, timer loaded WARN_CYCLES-1.
  - WARN: road YELLOW, gate_cmd 0. Counts down; at 0 -> LOWER, timer loaded GATE_TIMEOUT-1. Exactly WARN_CYCLES cycles of YELLOW.
  - LOWER: road RED, gate_cmd 1. gate_down -> CLOSED. Timer expiry without gate_down -> FAULT.
  - CLOSED: road RED, gate_cmd 1, all tracks GREEN. !any_occ -> CLEAR, timer loaded CLEAR_CYCLES-1.
  - CLEAR: road RED, gate_cmd 1, all tracks RED. arrive -> CLOSED (re-trigger). Timer 0 -> RAISE, timer loaded GATE_TIMEOUT-1.
  - RAISE: road RED, gate_cmd 0, tracks RED. arrive -> LOWER with fresh timeout. Otherwise gate_up -> OPEN; timer expiry -> FAULT.
  - FAULT: road RED, gate_cmd 1, all tracks YELLOW (caution), fault=1. Leaves only on clr.
- Track signals are never GREEN unless gate_down was seen in LOWER; no track GREEN while road is not RED.
- Arrivals during WARN or LOWER only update counters; the sequence continues.
- clr mid-operation immediately forces reset values, including the gate raise command. The external interlock is responsible during reset.
- gate_up and gate_down both high: treated as sensor fault. In LOWER or RAISE -> FAULT next edge.
- Timers are log2-sized from the largest of WARN_CYCLES, CLEAR_CYCLES and GATE_TIMEOUT.

Test Plan:
1. Reset, then clr=0, no stimulus -> road=10, track=all 00, gate_cmd=0 for 20 cycles.
2. N_TRACKS=2: train_in=01 one cycle; gate_down 3 cycles after gate_cmd rises; train_out=01 after 30 cycles; gate_up 2 cycles after gate_cmd falls -> road YELLOW exactly 8 cycles; track=1010 only while CLOSED; 4 RED-track CLEAR cycles; road GREEN after gate_up.
3. Two trains: train_in=11 together, exits track0 then track1 10 cycles apart -> busy held until second exit; CLEAR starts only after second exit.
4. Re-trigger: train_in=10 during CLEAR -> back to CLOSED, tracks GREEN. train_in during RAISE -> gate_cmd returns to 1, state LOWER.
5. Timeout: gate_down never asserted -> fault=1, road=00, track=all 01 after exactly 16 LOWER cycles; stays until clr.
6. Errors: train_out=01 with counter 0 -> seq_err=1, counter 0. train_in=train_out=01 same cycle -> counter unchanged.
